// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - 5-bit opcode encodings
//   - handshake FSM state type
//   - is_multicycle(): true for the opcodes that use the iterative engine
package alu_pkg;

  localparam logic [4:0] OpLoad  = 5'b00000;
  localparam logic [4:0] OpLoadi = 5'b00001;
  localparam logic [4:0] OpStore = 5'b00010;
  localparam logic [4:0] OpAdd   = 5'b00011;
  localparam logic [4:0] OpSub   = 5'b00100;
  localparam logic [4:0] OpShr   = 5'b00101;
  localparam logic [4:0] OpShl   = 5'b00110;
  localparam logic [4:0] OpRor   = 5'b00111;
  localparam logic [4:0] OpRol   = 5'b01000;
  localparam logic [4:0] OpAnd   = 5'b01001;
  localparam logic [4:0] OpOr    = 5'b01010;
  localparam logic [4:0] OpAddi  = 5'b01011;
  localparam logic [4:0] OpAndi  = 5'b01100;
  localparam logic [4:0] OpOri   = 5'b01101;
  localparam logic [4:0] OpMul   = 5'b01110;
  localparam logic [4:0] OpDiv   = 5'b01111;
  localparam logic [4:0] OpNeg   = 5'b10000;
  localparam logic [4:0] OpNot   = 5'b10001;

  typedef enum logic [1:0] {IDLE, MULDIV, DONE} state_e;

  // Divide by zero is resolved in one cycle by the caller, despite being OpDiv.
  function automatic logic is_multicycle(input logic [4:0] opcode);
    return (opcode == OpMul) || (opcode == OpDiv);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bus of the sequential ALU.
//   master (control unit): drives start, opcode, A, B; sees ready, done, div_zero, C
//   slave  (alu_seq):      the reverse
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic [4:0]         opcode;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               ready;
  logic               done;
  logic               div_zero;
  logic [2*WIDTH-1:0] C;

  modport master (
    output start, opcode, A, B,
    input  ready, done, div_zero, C
  );

  modport slave (
    input  start, opcode, A, B,
    output ready, done, div_zero, C
  );
endinterface

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: iterative signed multiply (shift-add) and divide (restoring).
// Operands are converted to magnitudes on load, WIDTH steps run the unsigned
// engine, and signs are re-applied combinationally on the outputs.
//   clk, clear  clock, async active-high reset
//   load        capture A/B and op_is_div, restart the iteration counter
//   step        run one iteration (ignored once finished)
//   hi, lo      signed result: product HI/LO, or remainder/quotient
//   last        all WIDTH iterations have completed
module alu_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             step,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);
  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0]   hi_q, lo_q, mag_b_q;
  logic [WIDTH-1:0]   hi_d, lo_d, abs_a, abs_b;
  logic               neg_a_q, neg_b_q, is_div_q, fin_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH:0]     sum, shifted, diff;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   quot, rem;

  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  assign abs_a = A[WIDTH-1] ? -A : A;
  assign abs_b = B[WIDTH-1] ? -B : B;

  // Multiply: lo holds the multiplier, shifted out LSB first; hi accumulates.
  assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_q} : '0);
  // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  assign shifted = {hi_q, lo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, mag_b_q};

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (is_div_q) begin
      if (!diff[WIDTH]) begin
        hi_d = diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      hi_q     <= '0;
      lo_q     <= '0;
      mag_b_q  <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      fin_q    <= 1'b0;
    end else if (load) begin
      hi_q     <= '0;
      lo_q     <= abs_a;
      mag_b_q  <= abs_b;
      neg_a_q  <= A[WIDTH-1];
      neg_b_q  <= B[WIDTH-1];
      is_div_q <= op_is_div;
      cnt_q    <= '0;
      fin_q    <= 1'b0;
    end else if (step && !fin_q) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (cnt_q == CntW'(WIDTH - 1)) begin
        fin_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Quotient is negative when signs differ; remainder follows the dividend.
  assign prod_mag = {hi_q, lo_q};
  assign prod     = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;
  assign quot     = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
  assign rem      = neg_a_q ? -hi_q : hi_q;

  assign hi   = is_div_q ? rem  : prod[2*WIDTH-1:WIDTH];
  assign lo   = is_div_q ? quot : prod[WIDTH-1:0];
  assign last = fin_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a start/ready handshake.
// Single-cycle ops complete on the accepting edge; mul and div (B != 0) run on
// alu_muldiv_unit and finish WIDTH+1 edges after acceptance.
//   clk    clock, rising edge
//   clear  async active-high reset; aborts any operation in flight
//   bus    alu_seq_if slave: start/opcode/A/B in; ready/done/div_zero/C out
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     clear,
  alu_seq_if.slave bus
);
  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] c_q, c_d, sc_c;
  logic               dz_q, dz_d, sc_dz;
  logic               accept, div_by_zero, md_load, md_step, md_last;
  logic [WIDTH-1:0]   md_hi, md_lo;
  logic [SHAMT_W-1:0] shamt;
  logic [2*WIDTH-1:0] rol_tmp, ror_tmp;

  assign accept      = bus.start && bus.ready;
  assign div_by_zero = (bus.opcode == OpDiv) && (bus.B == '0);

  // Rotates via a doubled operand: the wrapped bits land in the kept half.
  assign shamt   = bus.B[SHAMT_W-1:0];
  assign rol_tmp = {bus.A, bus.A} << shamt;
  assign ror_tmp = {bus.A, bus.A} >> shamt;

  always_comb begin
    sc_c  = '0;
    sc_dz = 1'b0;
    case (bus.opcode)
      OpLoad, OpLoadi, OpStore, OpAdd, OpAddi: sc_c[WIDTH-1:0] = bus.A + bus.B;
      OpSub:         sc_c[WIDTH-1:0] = bus.A - bus.B;
      OpShr:         sc_c[WIDTH-1:0] = bus.A >> shamt;
      OpShl:         sc_c[WIDTH-1:0] = bus.A << shamt;
      OpRor:         sc_c[WIDTH-1:0] = ror_tmp[WIDTH-1:0];
      OpRol:         sc_c[WIDTH-1:0] = rol_tmp[2*WIDTH-1:WIDTH];
      OpAnd, OpAndi: sc_c[WIDTH-1:0] = bus.A & bus.B;
      OpOr, OpOri:   sc_c[WIDTH-1:0] = bus.A | bus.B;
      OpNeg:         sc_c[WIDTH-1:0] = -bus.B;
      OpNot:         sc_c[WIDTH-1:0] = ~bus.B;
      // Only reached with B == 0; real divides go to the iterative engine.
      OpDiv: begin
        sc_c  = {bus.A, {WIDTH{1'b1}}};
        sc_dz = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    dz_d    = dz_q;
    md_load = 1'b0;
    md_step = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (is_multicycle(bus.opcode) && !div_by_zero) begin
            md_load = 1'b1;
            state_d = MULDIV;
          end else begin
            c_d     = sc_c;
            dz_d    = sc_dz;
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MULDIV: begin
        md_step = 1'b1;
        // One edge after the final iteration: capture the sign-corrected result.
        if (md_last) begin
          c_d     = {md_hi, md_lo};
          dz_d    = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      c_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      dz_q    <= dz_d;
    end
  end

  alu_muldiv_unit #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk       (clk),
    .clear     (clear),
    .load      (md_load),
    .op_is_div (bus.opcode == OpDiv),
    .A         (bus.A),
    .B         (bus.B),
    .step      (md_step),
    .hi        (md_hi),
    .lo        (md_lo),
    .last      (md_last)
  );

  assign bus.ready    = (state_q != MULDIV);
  assign bus.done     = (state_q == DONE);
  assign bus.div_zero = dz_q;
  assign bus.C        = c_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_pkg::*;

  logic clk;
  logic clear;
  int   n_checks;
  int   n_errors;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(
    .WIDTH (32)
  ) u_dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: results from signed integer arithmetic. done_edge counts clock
  // edges after the accepting edge until done is seen (0 = same edge).
  function automatic void model(input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [63:0] c,
                                output logic dz, output int done_edge);
    longint    q, r;
    logic [31:0] t;
    int        n;
    c = '0;
    dz = 1'b0;
    done_edge = 0;
    t = a;
    n = int'(b % 32);
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd11: c = {32'd0, a + b};
      5'd4:  c = {32'd0, a - b};
      5'd5:  c = {32'd0, a >> (b % 32)};
      5'd6:  c = {32'd0, a << (b % 32)};
      5'd7: begin
        for (int i = 0; i < n; i++) t = {t[0], t[31:1]};
        c = {32'd0, t};
      end
      5'd8: begin
        for (int i = 0; i < n; i++) t = {t[30:0], t[31]};
        c = {32'd0, t};
      end
      5'd9, 5'd12:  c = {32'd0, a & b};
      5'd10, 5'd13: c = {32'd0, a | b};
      5'd14: begin
        c = longint'($signed(a)) * longint'($signed(b));
        done_edge = 33;
      end
      5'd15: begin
        if (b == 0) begin
          c  = {a, 32'hFFFF_FFFF};
          dz = 1'b1;
        end else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          c = {r[31:0], q[31:0]};
          done_edge = 33;
        end
      end
      5'd16: c = {32'd0, -b};
      5'd17: c = {32'd0, ~b};
      default: c = '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [63:0] exp_c;
    logic        exp_dz;
    int          exp_edge;
    int          e;
    model(op, a, b, exp_c, exp_dz, exp_edge);
    check_eq({tag, ":ready"}, 64'(bus.ready), 64'd1);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.A      = a;
    bus.B      = b;
    tick();
    // Scramble inputs: the operation in flight must use the latched operands.
    bus.start  = 1'b0;
    bus.opcode = 5'($urandom);
    bus.A      = $urandom;
    bus.B      = $urandom;
    e = 0;
    while (!bus.done && e < 100) begin
      tick();
      e++;
    end
    check_eq({tag, ":latency"}, 64'(e), 64'(exp_edge));
    check_eq({tag, ":C"}, bus.C, exp_c);
    check_eq({tag, ":div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
  endtask

  initial begin
    int busy, e, ndone;
    logic [4:0]  op;
    logic [31:0] a, b;
    n_checks   = 0;
    n_errors   = 0;
    clear      = 1'b1;
    bus.start  = 1'b0;
    bus.opcode = '0;
    bus.A      = '0;
    bus.B      = '0;
    #12;
    check_eq("rst:ready", 64'(bus.ready), 64'd1);
    check_eq("rst:done", 64'(bus.done), 64'd0);
    check_eq("rst:div_zero", 64'(bus.div_zero), 64'd0);
    check_eq("rst:C", bus.C, 64'd0);
    #1 clear = 1'b0;
    tick();

    run_op("mul_m6x7", OpMul, 32'hFFFF_FFFA, 32'd7);
    tick();
    check_eq("mul:done_pulse", 64'(bus.done), 64'd0);
    check_eq("mul:C_hold", bus.C, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op("div_m17d5", OpDiv, 32'hFFFF_FFEF, 32'd5);
    run_op("div_zero", OpDiv, 32'd9, 32'd0);
    run_op("add_after_dz", OpAdd, 32'd4, 32'd5);
    run_op("rol", OpRol, 32'h8000_0001, 32'd33);
    run_op("shr", OpShr, 32'h8000_0000, 32'd4);
    run_op("neg", OpNeg, 32'd0, 32'd1);
    run_op("nop", 5'd20, 32'd7, 32'd8);
    run_op("div_minovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    tick();

    // start held high through a mul: only the mul completes, then the add is
    // accepted on the DONE cycle.
    bus.start  = 1'b1;
    bus.opcode = OpMul;
    bus.A      = 32'hFFFF_FFFA;
    bus.B      = 32'd7;
    tick();
    bus.opcode = OpAdd;
    bus.A      = 32'd2;
    bus.B      = 32'd3;
    busy = 0;
    e    = 0;
    while (!bus.done && e < 100) begin
      if (!bus.ready) busy++;
      tick();
      e++;
    end
    check_eq("busy:ready_low", 64'(busy), 64'd33);
    check_eq("busy:C_mul", bus.C, 64'hFFFF_FFFF_FFFF_FFD6);
    tick();
    bus.start = 1'b0;
    check_eq("busy:done2", 64'(bus.done), 64'd1);
    check_eq("busy:C_add", bus.C, 64'd5);
    tick();
    check_eq("busy:done_fall", 64'(bus.done), 64'd0);

    // Clear ten cycles into a mul aborts it without a done pulse.
    bus.start  = 1'b1;
    bus.opcode = OpMul;
    bus.A      = 32'd1000;
    bus.B      = 32'd1000;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    clear = 1'b1;
    #1;
    check_eq("clr:ready", 64'(bus.ready), 64'd1);
    check_eq("clr:C", bus.C, 64'd0);
    check_eq("clr:done", 64'(bus.done), 64'd0);
    #2 clear = 1'b0;
    ndone = 0;
    repeat (40) begin
      tick();
      if (bus.done) ndone++;
    end
    check_eq("clr:no_done", 64'(ndone), 64'd0);
    run_op("clr_add", OpAdd, 32'd2, 32'd3);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       op = OpMul;
        1:       op = OpDiv;
        default: op = 5'($urandom_range(0, 31));
      endcase
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($signed(12'($urandom)));
      if ($urandom_range(0, 3) == 0) b = 32'($signed(8'($urandom)));
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
